branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry direction state for the RV32I pipeline.
- IF-stage side: looks up the fetch PC and supplies a predicted direction and target to the next-PC mux.
- EX-stage side: consumes the resolved branch outcome (br) and the computed target from the branch-decision stage, updates the table, and raises mispredict/redirect toward the hazard unit.
- Also keeps branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS (derived, not overridable), tag = pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_if  input  32  IF-stage fetch PC to look up.
- pred_taken  output  1  combinational: predict taken for pc_if.
- pred_target  output  32  combinational: predicted target; 0 when pred_taken=0.
- ex_valid  input  1  EX holds a conditional branch (br_type != NOBRANCH), not stalled or flushed.
- ex_pc  input  32  PC of the EX-stage branch.
- ex_br  input  1  resolved outcome from branch decision (1 = taken).
- ex_target  input  32  computed branch target (pc + imm).
- ex_pred_taken  input  1  pred_taken carried down the pipeline with the instruction.
- ex_pred_target  input  32  pred_target carried with the instruction.
- mispredict  output  1  combinational: flush IF/ID and redirect.
- redirect_pc  output  32  combinational: correct next PC.
- br_cnt  output  32  registered count of resolved branches.
- mispred_cnt  output  32  registered count of mispredictions.

Behaviour:
- Per entry: valid (1b), tag (TAG_BITS), target (32b), ctr (2b).
- Reset (rst_n low, asynchronous): all valid=0, all ctr=2'b01, br_cnt=0, mispred_cnt=0. Consequently pred_taken=0, pred_target=0, and mispredict=0 while ex_valid=0.
- Lookup (0-cycle, combinational from registered table): hit = valid[idx] && tag[idx]==pc_if tag; pred_taken = hit && ctr[idx][1]; pred_target = pred_taken ? target[idx] : 0.
- mispredict = ex_valid && ((ex_br != ex_pred_taken) || (ex_br && ex_pred_target != ex_target)).
- redirect_pc = ex_br ? ex_target : ex_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
- Update (rising edge, only when ex_valid=1), at ex_pc's index:
  - hit && ex_br: ctr saturating increment (max 3); target <= ex_target.
  - hit && !ex_br: ctr saturating decrement (min 0); entry stays valid.
  - miss && ex_br: allocate, replacing any previous entry: valid=1, tag, target=ex_target, ctr=2'b10.
  - miss && !ex_br: no change.
- Simultaneous lookup and update to the same index in one cycle: lookup returns pre-update contents. The new value is visible the following cycle.
- Statistics:
  - br_cnt += 1 on each ex_valid cycle.
  - mispred_cnt += 1 on each mispredict cycle.
  - Both wrap modulo 2^32.
- Reset mid-operation clears the table immediately. Any in-flight ex_pred_* from before reset is the pipeline's responsibility; the pipeline is also reset.

Optional Feature:
- Macro: BP_2BIT_COUNTER_EN.
- Defined: 2-bit saturating counters exactly as above.
- Undefined: ctr storage is removed and prediction is 1-bit.
  - pred_taken = hit.
  - hit && !ex_br clears valid.
  - Taken branches allocate or refresh the entry as above.
  - All other rules are unchanged.

Test Plan:
- Reset, then pc_if=0x100 -> pred_taken=0, pred_target=0, br_cnt=0, mispred_cnt=0.
- ex_valid=1, ex_pc=0x100, ex_br=1, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle pc_if=0x100 gives pred_taken=1, pred_target=0x80; counters 1/1.
- Same branch resolved not-taken once with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104, ctr 2->1. Then pred_taken=0 (macro on) or entry invalid (macro off).
- Four consecutive taken updates of 0x100 saturate ctr at 3. One not-taken update -> ctr=2, pred_taken still 1 (macro on).
- Alias: 0x100 allocated, then 0x200 (same index with INDEX_BITS=6) taken to 0x40 -> lookup 0x100 misses, lookup 0x200 hits with target 0x40. Same-cycle lookup of 0x200 during its allocation returns miss.
- Correct taken prediction with a wrong target (ex_pred_target=0x80, ex_target=0x90) -> mispredict=1, redirect_pc=0x90, entry target updated to 0x90.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction state: IF-stage lookup, EX-stage update and redirect.
// Define BP_2BIT_COUNTER_EN for 2-bit saturating counters; otherwise prediction is 1-bit (hit means taken).
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_br,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   typedef logic [INDEX_BITS-1:0] idx_t;
   typedef logic [TAG_BITS-1:0]   tag_t;

   logic        valid_q  [ENTRIES];
   tag_t        tag_q    [ENTRIES];
   logic [31:0] target_q [ENTRIES];
`ifdef BP_2BIT_COUNTER_EN
   logic [1:0]  ctr_q    [ENTRIES];
   logic [1:0]  entCtr_d;
`endif
   logic [31:0] brCnt_q, brCnt_d;
   logic [31:0] mispredCnt_q, mispredCnt_d;

   idx_t        lkIdx, exIdx;
   tag_t        lkTag, exTag;
   logic        lkHit, exHit;
   logic        entWe, entValid_d;
   tag_t        entTag_d;
   logic [31:0] entTarget_d;
   logic        unused_pcLow;

   assign lkIdx        = pc_if[INDEX_BITS+1:2];
   assign lkTag        = pc_if[31:INDEX_BITS+2];
   assign exIdx        = ex_pc[INDEX_BITS+1:2];
   assign exTag        = ex_pc[31:INDEX_BITS+2];
   assign unused_pcLow = ^pc_if[1:0];

   // Lookup reads only registered state, so a same-cycle update is seen next cycle.
   assign lkHit = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
   assign exHit = valid_q[exIdx] && (tag_q[exIdx] == exTag);

`ifdef BP_2BIT_COUNTER_EN
   assign pred_taken = lkHit && ctr_q[lkIdx][1];
`else
   assign pred_taken = lkHit;
`endif
   assign pred_target = pred_taken ? target_q[lkIdx] : 32'd0;

   assign mispredict  = ex_valid && ((ex_br != ex_pred_taken) ||
                                     (ex_br && (ex_pred_target != ex_target)));
   assign redirect_pc = ex_br ? ex_target : ex_pc + 32'd4;

   assign brCnt_d      = ex_valid   ? brCnt_q + 32'd1      : brCnt_q;
   assign mispredCnt_d = mispredict ? mispredCnt_q + 32'd1 : mispredCnt_q;

   always_comb begin
      entWe       = 1'b0;
      entValid_d  = valid_q[exIdx];
      entTag_d    = tag_q[exIdx];
      entTarget_d = target_q[exIdx];
`ifdef BP_2BIT_COUNTER_EN
      entCtr_d    = ctr_q[exIdx];
`endif
      if (ex_valid) begin
         if (exHit && ex_br) begin
            entWe       = 1'b1;
            entTarget_d = ex_target;
`ifdef BP_2BIT_COUNTER_EN
            if (ctr_q[exIdx] != 2'b11) entCtr_d = ctr_q[exIdx] + 2'd1;
`endif
         end else if (exHit) begin
            entWe = 1'b1;
`ifdef BP_2BIT_COUNTER_EN
            if (ctr_q[exIdx] != 2'b00) entCtr_d = ctr_q[exIdx] - 2'd1;
`else
            entValid_d = 1'b0;
`endif
         end else if (ex_br) begin
            // Taken miss replaces whatever aliased entry lived at this index.
            entWe       = 1'b1;
            entValid_d  = 1'b1;
            entTag_d    = exTag;
            entTarget_d = ex_target;
`ifdef BP_2BIT_COUNTER_EN
            entCtr_d    = 2'b10;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
`ifdef BP_2BIT_COUNTER_EN
            ctr_q[i]    <= 2'b01;
`endif
         end
         brCnt_q      <= '0;
         mispredCnt_q <= '0;
      end else begin
         if (entWe) begin
            valid_q[exIdx]  <= entValid_d;
            tag_q[exIdx]    <= entTag_d;
            target_q[exIdx] <= entTarget_d;
`ifdef BP_2BIT_COUNTER_EN
            ctr_q[exIdx]    <= entCtr_d;
`endif
         end
         brCnt_q      <= brCnt_d;
         mispredCnt_q <= mispredCnt_d;
      end
   end

   assign br_cnt      = brCnt_q;
   assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, async reset, then random traffic vs a model.
module tb_branch_predictor;

`ifdef BP_2BIT_COUNTER_EN
   localparam bit CTR2 = 1'b1;
`else
   localparam bit CTR2 = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_br;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;

   int testsRun  = 0;
   int failCount = 0;

   branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br(ex_br), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pcIf;
      logic        exValid;
      logic [31:0] exPc;
      logic        exBr;
      logic [31:0] exTarget;
      logic        exPredTaken;
      logic [31:0] exPredTarget;
      logic        expTaken;
      logic [31:0] expTarget;
      logic        expMis;
      logic [31:0] expRedirect;
      logic [31:0] expBrCnt;
      logic [31:0] expMisCnt;
   } vec_t;

   vec_t vecs[$];

   // Reference model: one record per table slot, prediction strength kept as a plain integer 0..3.
   bit          mValid    [64];
   bit [31:0]   mTag      [64];
   bit [31:0]   mTarget   [64];
   int          mStrength [64];
   bit [31:0]   mBr, mMis;

   function automatic int slotOf(input bit [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic bit modelHit(input bit [31:0] pc);
      return mValid[slotOf(pc)] && (mTag[slotOf(pc)] == pc / 256);
   endfunction

   function automatic bit modelTaken(input bit [31:0] pc);
      if (CTR2) return modelHit(pc) && (mStrength[slotOf(pc)] >= 2);
      return modelHit(pc);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) begin
         mValid[i]    = 1'b0;
         mTag[i]      = 0;
         mTarget[i]   = 0;
         mStrength[i] = 1;
      end
      mBr  = 0;
      mMis = 0;
   endtask

   task automatic modelUpdate(input bit [31:0] pc, input bit br, input bit [31:0] tgt);
      int s;
      s = slotOf(pc);
      if (modelHit(pc)) begin
         if (br) begin
            mStrength[s] = (mStrength[s] + 1 > 3) ? 3 : mStrength[s] + 1;
            mTarget[s]   = tgt;
         end else if (CTR2) begin
            mStrength[s] = (mStrength[s] - 1 < 0) ? 0 : mStrength[s] - 1;
         end else begin
            mValid[s] = 1'b0;
         end
      end else if (br) begin
         mValid[s]    = 1'b1;
         mTag[s]      = pc / 256;
         mTarget[s]   = tgt;
         mStrength[s] = 2;
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pcIf, input logic v, input logic [31:0] exPc,
                               input logic br, input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ptt, input logic eT, input logic [31:0] eTg,
                               input logic eM, input logic [31:0] eR, input logic [31:0] eB,
                               input logic [31:0] eMC);
      vec_t r;
      r.pcIf = pcIf; r.exValid = v; r.exPc = exPc; r.exBr = br; r.exTarget = tgt;
      r.exPredTaken = pt; r.exPredTarget = ptt; r.expTaken = eT; r.expTarget = eTg;
      r.expMis = eM; r.expRedirect = eR; r.expBrCnt = eB; r.expMisCnt = eMC;
      return r;
   endfunction

   task automatic checkOne(input string label, input string field,
                           input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s %s: actual %h required %h", label, field, act, exp);
      end
   endtask

   // Inputs change just after a rising edge; outputs are sampled mid-cycle.
   task automatic applyStimulus(input vec_t v);
      pc_if          = v.pcIf;
      ex_valid       = v.exValid;
      ex_pc          = v.exPc;
      ex_br          = v.exBr;
      ex_target      = v.exTarget;
      ex_pred_taken  = v.exPredTaken;
      ex_pred_target = v.exPredTarget;
      #4;
   endtask

   task automatic checkOutput(input string label, input vec_t v);
      checkOne(label, "pred_taken",  {31'd0, pred_taken}, {31'd0, v.expTaken});
      checkOne(label, "pred_target", pred_target, v.expTarget);
      checkOne(label, "mispredict",  {31'd0, mispredict}, {31'd0, v.expMis});
      checkOne(label, "redirect_pc", redirect_pc, v.expRedirect);
      checkOne(label, "br_cnt",      br_cnt, v.expBrCnt);
      checkOne(label, "mispred_cnt", mispred_cnt, v.expMisCnt);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      bit [31:0] rPc;
      rst_n = 1'b0;
      pc_if = 0; ex_valid = 0; ex_pc = 0; ex_br = 0;
      ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
      modelReset();

      //        pcIf          v  exPc          br tgt    pt ptt  | eT eTg  eM eRedir  eB  eMC
      vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h4,   0, 0));
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0,  0, 32'h0,  1, 32'h80,  0, 0));
      vecs.push_back(mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,  1, 32'h80, 0, 32'h104, 1, 1));
      vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104, 1, 1));
      vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h4,   2, 2));
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0,  0, 32'h0,  1, 32'h80,  2, 2));
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80,  3, 3));
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80,  4, 3));
      vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80,  5, 3));
      vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104, 6, 3));
      vecs.push_back(mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,  CTR2, CTR2 ? 32'h80 : 32'h0,
                        0, 32'h104, 7, 4));
      vecs.push_back(mk(32'h300, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0, 32'h0,  0, 32'h80,  7, 4));
      vecs.push_back(mk(32'h200, 1, 32'h200, 1, 32'h40, 0, 32'h0,  0, 32'h0,  1, 32'h40,  8, 4));
      vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h4,   9, 5));
      vecs.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,  0, 32'h0,  1, 32'h40, 0, 32'h4,   9, 5));
      vecs.push_back(mk(32'h200, 1, 32'h200, 1, 32'h90, 1, 32'h80, 1, 32'h40, 1, 32'h90,  9, 5));
      vecs.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,  0, 32'h0,  1, 32'h90, 0, 32'h4,  10, 6));
      vecs.push_back(mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h1234, 0, 32'h0, 0, 32'h0, 0, 32'h0, 10, 6));
      vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 1, 32'h0,  0, 32'h0,  0, 32'h4,  11, 6));

      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      nextCycle();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
         nextCycle();
      end

      // Asynchronous reset in the middle of a cycle must clear the live entry at once.
      v = mk(32'h200, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h90, 0, 32'h4, 11, 6);
      applyStimulus(v);
      checkOne("midreset_before", "pred_taken", {31'd0, pred_taken}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOne("midreset", "pred_taken",  {31'd0, pred_taken}, 32'd0);
      checkOne("midreset", "pred_target", pred_target, 32'd0);
      checkOne("midreset", "br_cnt",      br_cnt, 32'd0);
      checkOne("midreset", "mispred_cnt", mispred_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      nextCycle();

      // Random traffic over a few aliasing PCs so hits, misses and replacements all occur.
      for (int n = 0; n < 400; n++) begin
         v.pcIf     = ($urandom_range(0, 2) * 256) + ($urandom_range(0, 3) * 4);
         rPc        = ($urandom_range(0, 2) * 256) + ($urandom_range(0, 3) * 4);
         v.exValid  = ($urandom_range(0, 4) != 0);
         v.exPc     = rPc;
         v.exBr     = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: v.exTarget = 32'h40;
            1: v.exTarget = 32'h80;
            2: v.exTarget = 32'h90;
            default: v.exTarget = $urandom & 32'hFFFFFFFC;
         endcase
         if ($urandom_range(0, 3) != 0) begin
            v.exPredTaken  = modelTaken(rPc);
            v.exPredTarget = v.exPredTaken ? mTarget[slotOf(rPc)] : 32'd0;
         end else begin
            v.exPredTaken  = $urandom_range(0, 1);
            v.exPredTarget = v.exPredTaken ? v.exTarget : 32'd0;
         end
         v.expTaken    = modelTaken(v.pcIf);
         v.expTarget   = v.expTaken ? mTarget[slotOf(v.pcIf)] : 32'd0;
         v.expMis      = v.exValid && ((v.exBr != v.exPredTaken) ||
                                       (v.exBr && v.exPredTarget != v.exTarget));
         v.expRedirect = v.exBr ? v.exTarget : v.exPc + 32'd4;
         v.expBrCnt    = mBr;
         v.expMisCnt   = mMis;
         applyStimulus(v);
         checkOutput($sformatf("rand%0d", n), v);
         if (v.exValid) begin
            mBr = mBr + 1;
            if (v.expMis) mMis = mMis + 1;
            modelUpdate(v.exPc, v.exBr, v.exTarget);
         end
         nextCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
